// File: rtl/cpu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_seq_if
// Purpose  : Bundle of signals between the SAP-1 controller-sequencer and the
//            datapath: run enable, opcode in, control word and status out.
// Ports    : en      - 1 = advance one T-state per clock
//            opcode  - IR[7:4]
//            cp..lo  - control word (PC, MAR, ROM, IR, A, ALU, B, OUT)
//            halted  - HLT executed, sequencer frozen
//            tstate  - one-hot ring state, bit0 = T1
// Modports : master - the controller (drives the control word)
//            slave  - the datapath / environment (drives en and opcode)
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_ctrl_seq_if;
  logic       en;
  logic [3:0] opcode;
  logic       cp;
  logic       ep;
  logic       lm;
  logic       em;
  logic       li;
  logic       ei;
  logic       la;
  logic       ea;
  logic       su;
  logic       eu;
  logic       lb;
  logic       lo;
  logic       halted;
  logic [5:0] tstate;

  modport master (
    input  en, opcode,
    output cp, ep, lm, em, li, ei, la, ea, su, eu, lb, lo, halted, tstate
  );

  modport slave (
    output en, opcode,
    input  cp, ep, lm, em, li, ei, la, ea, su, eu, lb, lo, halted, tstate
  );
endinterface
`default_nettype wire

// File: rtl/cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_seq
// Purpose  : SAP-1 controller-sequencer. A one-hot T1..T6 ring counter plus
//            opcode decode produces the control word for PC, MAR, ROM, IR,
//            A, B, ALU and OUT. This block is the only source of every bus
//            enable, so it guarantees a single bus driver per state.
// Ports    : clk - system clock, rising edge
//            rst - asynchronous reset, active-high
//            bus - cpu_ctrl_seq_if.master: en/opcode in; control word,
//                  halted and tstate out
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ctrl_seq #(
  parameter logic [3:0] OP_LDA       = 4'h0,
  parameter logic [3:0] OP_ADD       = 4'h1,
  parameter logic [3:0] OP_SUB       = 4'h2,
  parameter logic [3:0] OP_OUT       = 4'hE,
  parameter logic [3:0] OP_HLT       = 4'hF,
  parameter bit         EARLY_RETIRE = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  cpu_ctrl_seq_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e r_state;
  tstate_e w_state_next;
  logic    r_halted;
  logic    w_halted_next;

  // Opcode decode. Anything not listed is a NOP.
  logic w_is_lda;
  logic w_is_add;
  logic w_is_sub;
  logic w_is_out;
  logic w_is_hlt;
  logic w_is_mem;
  logic w_is_nop;

  assign w_is_lda = (bus.opcode == OP_LDA);
  assign w_is_add = (bus.opcode == OP_ADD);
  assign w_is_sub = (bus.opcode == OP_SUB);
  assign w_is_out = (bus.opcode == OP_OUT);
  assign w_is_hlt = (bus.opcode == OP_HLT);
  assign w_is_mem = w_is_lda | w_is_add | w_is_sub;
  assign w_is_nop = ~(w_is_mem | w_is_out | w_is_hlt);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= T1;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_halted <= w_halted_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_halted_next = r_halted;
    // Once halted, only rst can restart the ring; en is ignored.
    if (!r_halted && bus.en) begin
      case (r_state)
        T1: w_state_next = T2;
        T2: w_state_next = T3;
        T3: w_state_next = T4;
        T4: begin
          if (w_is_hlt) begin
            // Ring freezes on T4 so the debug view shows where HLT stopped.
            w_halted_next = 1'b1;
            w_state_next  = T4;
          end else if (EARLY_RETIRE && (w_is_out || w_is_nop)) begin
            w_state_next = T1;
          end else begin
            w_state_next = T5;
          end
        end
        T5: begin
          if (EARLY_RETIRE && w_is_lda) begin
            w_state_next = T1;
          end else begin
            w_state_next = T6;
          end
        end
        T6:      w_state_next = T1;
        // A corrupted (non one-hot) ring recovers to fetch.
        default: w_state_next = T1;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control word decode
  // --------------------------------------------------------------------------
  logic w_cp;
  logic w_ep;
  logic w_lm;
  logic w_em;
  logic w_li;
  logic w_ei;
  logic w_la;
  logic w_ea;
  logic w_su;
  logic w_eu;
  logic w_lb;
  logic w_lo;

  always_comb begin
    w_cp = 1'b0;
    w_ep = 1'b0;
    w_lm = 1'b0;
    w_em = 1'b0;
    w_li = 1'b0;
    w_ei = 1'b0;
    w_la = 1'b0;
    w_ea = 1'b0;
    w_su = 1'b0;
    w_eu = 1'b0;
    w_lb = 1'b0;
    w_lo = 1'b0;
    // rst is folded in combinationally so no load or bus drive survives the
    // cycle in which reset asserts, even before the next clock edge.
    if (!rst && !r_halted) begin
      case (r_state)
        T1: begin
          w_ep = 1'b1;
          w_lm = 1'b1;
        end
        T2: begin
          w_cp = 1'b1;
        end
        T3: begin
          w_em = 1'b1;
          w_li = 1'b1;
        end
        T4: begin
          if (w_is_mem) begin
            w_ei = 1'b1;
            w_lm = 1'b1;
          end else if (w_is_out) begin
            w_ea = 1'b1;
            w_lo = 1'b1;
          end
        end
        T5: begin
          if (w_is_lda) begin
            w_em = 1'b1;
            w_la = 1'b1;
          end else if (w_is_add || w_is_sub) begin
            w_em = 1'b1;
            w_lb = 1'b1;
          end
        end
        T6: begin
          if (w_is_add || w_is_sub) begin
            w_eu = 1'b1;
            w_la = 1'b1;
            w_su = w_is_sub;
          end
        end
        default: begin
          w_cp = 1'b0;
        end
      endcase
    end
  end

  assign bus.cp     = w_cp;
  assign bus.ep     = w_ep;
  assign bus.lm     = w_lm;
  assign bus.em     = w_em;
  assign bus.li     = w_li;
  assign bus.ei     = w_ei;
  assign bus.la     = w_la;
  assign bus.ea     = w_ea;
  assign bus.su     = w_su;
  assign bus.eu     = w_eu;
  assign bus.lb     = w_lb;
  assign bus.lo     = w_lo;
  assign bus.halted = r_halted;
  assign bus.tstate = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl_seq
// Purpose  : Self-checking bench for cpu_ctrl_seq. Two instances are used:
//            dut0 with fixed 6-state instructions, dut1 with early retire.
//            Expected {tstate, control word, halted} triples are queued when
//            stimulus is applied and popped when the DUT state is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl_seq;

  // Control word bit positions: {cp,ep,lm,em,li,ei,la,ea,su,eu,lb,lo}
  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] LM = 12'h200;
  localparam logic [11:0] EM = 12'h100;
  localparam logic [11:0] LI = 12'h080;
  localparam logic [11:0] EI = 12'h040;
  localparam logic [11:0] LA = 12'h020;
  localparam logic [11:0] EA = 12'h010;
  localparam logic [11:0] SU = 12'h008;
  localparam logic [11:0] EU = 12'h004;
  localparam logic [11:0] LB = 12'h002;
  localparam logic [11:0] LO = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  typedef struct packed {
    logic [5:0]  ts;
    logic [11:0] cw;
    logic        h;
  } exp_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_ctrl_seq_if if0();
  cpu_ctrl_seq_if if1();

  cpu_ctrl_seq #(.EARLY_RETIRE(1'b0)) dut0 (.clk(clk), .rst(rst0), .bus(if0.master));
  cpu_ctrl_seq #(.EARLY_RETIRE(1'b1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.master));

  logic [11:0] cw0;
  logic [11:0] cw1;
  logic [5:0]  ts0;
  logic [5:0]  ts1;
  assign cw0 = {if0.cp, if0.ep, if0.lm, if0.em, if0.li, if0.ei,
                if0.la, if0.ea, if0.su, if0.eu, if0.lb, if0.lo};
  assign cw1 = {if1.cp, if1.ep, if1.lm, if1.em, if1.li, if1.ei,
                if1.la, if1.ea, if1.su, if1.eu, if1.lb, if1.lo};
  assign ts0 = if0.tstate;
  assign ts1 = if1.tstate;

  // Reference control word from the instruction table.
  function automatic logic [11:0] exp_cw(input logic [5:0] ts, input logic [3:0] op);
    case (ts)
      6'h01: return EP | LM;
      6'h02: return CP;
      6'h04: return EM | LI;
      6'h08: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) return EI | LM;
        else if (op == 4'hE) return EA | LO;
        else return NONE;
      end
      6'h10: begin
        if (op == 4'h0) return EM | LA;
        else if (op == 4'h1 || op == 4'h2) return EM | LB;
        else return NONE;
      end
      6'h20: begin
        if (op == 4'h1) return EU | LA;
        else if (op == 4'h2) return SU | EU | LA;
        else return NONE;
      end
      default: return NONE;
    endcase
  endfunction

  // Single-driver bus invariant on both instances, every cycle.
  always @(negedge clk) begin
    checks++;
    if ($countones({if0.ep, if0.em, if0.ei, if0.ea, if0.eu}) > 1) begin
      errors++;
      $display("FAIL bus_inv dut0 t=%0t: enables ep/em/ei/ea/eu=%b, want at most one set",
               $time, {if0.ep, if0.em, if0.ei, if0.ea, if0.eu});
    end
    checks++;
    if ($countones({if1.ep, if1.em, if1.ei, if1.ea, if1.eu}) > 1) begin
      errors++;
      $display("FAIL bus_inv dut1 t=%0t: enables ep/em/ei/ea/eu=%b, want at most one set",
               $time, {if1.ep, if1.em, if1.ei, if1.ea, if1.eu});
    end
  end

  task automatic pulse_rst0();
    rst0 = 1'b1;
    @(negedge clk); #1;
    rst0 = 1'b0;
    #1;
  endtask

  task automatic pulse_rst1();
    rst1 = 1'b1;
    @(negedge clk); #1;
    rst1 = 1'b0;
    #1;
  endtask

  // Reset state on both instances, then release dut0 into T1.
  task automatic test_reset();
    exp_t e;
    @(negedge clk); #1;
    sb.push_back({6'h01, NONE, 1'b0});
    sb.push_back({6'h01, NONE, 1'b0});
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      checks++;
      if ((i == 0 ? ts0 : ts1) !== e.ts || (i == 0 ? cw0 : cw1) !== e.cw ||
          (i == 0 ? if0.halted : if1.halted) !== e.h) begin
        errors++;
        $display("FAIL reset dut%0d: got ts=%h cw=%h h=%b, want ts=%h cw=%h h=%b",
                 i, (i == 0 ? ts0 : ts1), (i == 0 ? cw0 : cw1),
                 (i == 0 ? if0.halted : if1.halted), e.ts, e.cw, e.h);
      end
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
  endtask

  // LDA over the full ring with literal expected control words.
  task automatic test_lda_sequence();
    exp_t e;
    if0.opcode = 4'h0;
    sb.push_back({6'h01, EP | LM, 1'b0});
    sb.push_back({6'h02, CP,      1'b0});
    sb.push_back({6'h04, EM | LI, 1'b0});
    sb.push_back({6'h08, EI | LM, 1'b0});
    sb.push_back({6'h10, EM | LA, 1'b0});
    sb.push_back({6'h20, NONE,    1'b0});
    sb.push_back({6'h01, EP | LM, 1'b0});
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      e = sb.pop_front();
      checks++;
      if (ts0 !== e.ts || cw0 !== e.cw || if0.halted !== e.h) begin
        errors++;
        $display("FAIL lda step%0d: got ts=%h cw=%h h=%b, want ts=%h cw=%h h=%b",
                 i, ts0, cw0, if0.halted, e.ts, e.cw, e.h);
      end
    end
  endtask

  // SUB, ADD and an unknown opcode on the fixed 6-state sequencer.
  task automatic test_alu();
    logic [3:0] ops [3] = '{4'h2, 4'h1, 4'h7};
    exp_t e;
    foreach (ops[k]) begin
      if0.opcode = ops[k];
      for (int i = 0; i < 6; i++)
        sb.push_back({6'(1 << i), exp_cw(6'(1 << i), ops[k]), 1'b0});
      sb.push_back({6'h01, EP | LM, 1'b0});
      for (int i = 0; i < 7; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        e = sb.pop_front();
        checks++;
        if (ts0 !== e.ts || cw0 !== e.cw || if0.halted !== e.h) begin
          errors++;
          $display("FAIL alu op=%h step%0d: got ts=%h cw=%h h=%b, want ts=%h cw=%h h=%b",
                   ops[k], i, ts0, cw0, if0.halted, e.ts, e.cw, e.h);
        end
      end
    end
  endtask

  // Early retire: OUT/NOP leave after T4, LDA after T5, ADD/SUB run to T6.
  task automatic test_early_retire();
    logic [3:0] ops  [5] = '{4'hE, 4'h0, 4'h1, 4'h7, 4'h2};
    int         nst  [5] = '{4, 5, 6, 4, 6};
    exp_t e;
    if1.en = 1'b1;
    pulse_rst1();
    foreach (ops[k]) begin
      if1.opcode = ops[k];
      for (int i = 0; i < nst[k]; i++)
        sb.push_back({6'(1 << i), exp_cw(6'(1 << i), ops[k]), 1'b0});
      sb.push_back({6'h01, EP | LM, 1'b0});
      for (int i = 0; i <= nst[k]; i++) begin
        if (i > 0) begin @(negedge clk); #1; end
        e = sb.pop_front();
        checks++;
        if (ts1 !== e.ts || cw1 !== e.cw || if1.halted !== e.h) begin
          errors++;
          $display("FAIL early_retire op=%h step%0d: got ts=%h cw=%h h=%b, want ts=%h cw=%h h=%b",
                   ops[k], i, ts1, cw1, if1.halted, e.ts, e.cw, e.h);
        end
      end
    end
  endtask

  // HLT freezes at T4 with a dead control word; en toggling has no effect.
  task automatic test_halt();
    exp_t e;
    if0.en     = 1'b1;
    if0.opcode = 4'hF;
    pulse_rst0();
    sb.push_back({6'h01, EP | LM, 1'b0});
    sb.push_back({6'h02, CP,      1'b0});
    sb.push_back({6'h04, EM | LI, 1'b0});
    sb.push_back({6'h08, NONE,    1'b0});
    for (int i = 0; i < 20; i++) sb.push_back({6'h08, NONE, 1'b1});
    for (int i = 0; i < 24; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      e = sb.pop_front();
      checks++;
      if (ts0 !== e.ts || cw0 !== e.cw || if0.halted !== e.h) begin
        errors++;
        $display("FAIL halt step%0d: got ts=%h cw=%h h=%b, want ts=%h cw=%h h=%b",
                 i, ts0, cw0, if0.halted, e.ts, e.cw, e.h);
      end
      if (i >= 4) if0.en = (i % 3 != 0);
    end
    if0.en = 1'b1;
    if0.opcode = 4'h0;
    rst0 = 1'b1;
    #1;
    sb.push_back({6'h01, NONE,    1'b0});
    sb.push_back({6'h01, EP | LM, 1'b0});
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin @(negedge clk); #1; rst0 = 1'b0; #1; end
      e = sb.pop_front();
      checks++;
      if (ts0 !== e.ts || cw0 !== e.cw || if0.halted !== e.h) begin
        errors++;
        $display("FAIL halt_rst step%0d: got ts=%h cw=%h h=%b, want ts=%h cw=%h h=%b",
                 i, ts0, cw0, if0.halted, e.ts, e.cw, e.h);
      end
    end
  endtask

  // en=0 for three clocks in T3 holds state and control word.
  task automatic test_en_hold();
    logic en_after [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_t e;
    if0.en     = 1'b1;
    if0.opcode = 4'h0;
    pulse_rst0();
    sb.push_back({6'h01, EP | LM, 1'b0});
    sb.push_back({6'h02, CP,      1'b0});
    sb.push_back({6'h04, EM | LI, 1'b0});
    sb.push_back({6'h04, EM | LI, 1'b0});
    sb.push_back({6'h04, EM | LI, 1'b0});
    sb.push_back({6'h04, EM | LI, 1'b0});
    sb.push_back({6'h08, EI | LM, 1'b0});
    sb.push_back({6'h10, EM | LA, 1'b0});
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      e = sb.pop_front();
      checks++;
      if (ts0 !== e.ts || cw0 !== e.cw || if0.halted !== e.h) begin
        errors++;
        $display("FAIL en_hold step%0d: got ts=%h cw=%h h=%b, want ts=%h cw=%h h=%b",
                 i, ts0, cw0, if0.halted, e.ts, e.cw, e.h);
      end
      if0.en = en_after[i];
    end
  endtask

  // Asynchronous reset in the middle of LDA T5 kills em/la at once.
  task automatic test_rst_mid();
    exp_t e;
    if0.en     = 1'b1;
    if0.opcode = 4'h0;
    pulse_rst0();
    for (int i = 0; i < 5; i++)
      sb.push_back({6'(1 << i), exp_cw(6'(1 << i), 4'h0), 1'b0});
    sb.push_back({6'h01, NONE,    1'b0});
    sb.push_back({6'h01, NONE,    1'b0});
    sb.push_back({6'h01, EP | LM, 1'b0});
    sb.push_back({6'h02, CP,      1'b0});
    for (int i = 0; i < 9; i++) begin
      if (i > 0 && i != 5 && i != 7) begin @(negedge clk); #1; end
      if (i == 5) begin #2; rst0 = 1'b1; #1; end
      if (i == 7) begin rst0 = 1'b0; #1; end
      e = sb.pop_front();
      checks++;
      if (ts0 !== e.ts || cw0 !== e.cw || if0.halted !== e.h) begin
        errors++;
        $display("FAIL rst_mid step%0d: got ts=%h cw=%h h=%b, want ts=%h cw=%h h=%b",
                 i, ts0, cw0, if0.halted, e.ts, e.cw, e.h);
      end
    end
  endtask

  initial begin
    rst0       = 1'b1;
    rst1       = 1'b1;
    if0.en     = 1'b1;
    if0.opcode = 4'h0;
    if1.en     = 1'b1;
    if1.opcode = 4'h0;
    test_reset();
    test_lda_sequence();
    test_alu();
    test_early_retire();
    test_halt();
    test_en_hold();
    test_rst_mid();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
